// File: rtl/toy_boot_loader.sv
// ---------------------------------------------------------------------------
// toy_boot_loader
//
// Loads a framed program image from a valid/ready byte stream into the Toy
// CPU instruction memory and holds the CPU in reset until the whole image has
// arrived with a good checksum.
//
// Frame: COUNT_HI, COUNT_LO, N x (WORD_HI, WORD_LO), CHK. The 8-bit sum of
// every frame byte, CHK included, must be 0x00.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high
//   start       one-cycle load request (honoured in IDLE, DONE, ERROR)
//   rx_data     incoming byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte this cycle (decoded from state)
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   write address
//   imem_wdata  write data
//   cpu_reset   active-high hold for the CPU reset input
//   busy        a load is in progress (decoded from state)
//   done        last load succeeded (level)
//   error       last load failed (level)
// ---------------------------------------------------------------------------
module toy_boot_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    WORD_HI,
    WORD_LO,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Largest legal word count; kept 32 bits wide so the compare below never
  // truncates whatever ADDR_W is chosen.
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  state_t            state;
  state_t            state_next;

  logic [7:0]        sum;          // running 8-bit frame checksum
  logic [7:0]        count_hi;     // first count byte, held until COUNT_LO
  logic [7:0]        word_hi;      // high half of the word being assembled
  logic [ADDR_W:0]   n_words;      // validated word count
  logic [ADDR_W:0]   word_cnt;     // words written so far, one bit wider than
                                   // the address so 2^ADDR_W can be reached
  logic [ADDR_W:0]   word_cnt_inc;
  logic [15:0]       count_full;
  logic [7:0]        sum_next;

  logic              accept;
  logic              count_bad;
  logic              start_load;
  logic              write_word;
  logic              load_ok;
  logic              load_bad;

  // rx_ready and busy are pure state decodes, so they fall the instant the
  // state leaves the receiving states (including on asynchronous reset).
  assign rx_ready = (state == CNT_HI)  || (state == CNT_LO) ||
                    (state == WORD_HI) || (state == WORD_LO) ||
                    (state == CHECK);
  assign busy     = rx_ready;
  assign accept   = rx_valid && rx_ready;

  assign count_full   = {count_hi, rx_data};
  assign count_bad    = (count_full == 16'd0) || (32'(count_full) > MAX_WORDS);
  assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);
  assign sum_next     = sum + rx_data;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state and per-edge action decode
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    write_word = 1'b0;
    load_ok    = 1'b0;
    load_bad   = 1'b0;

    case (state)
      IDLE, DONE, ERROR: begin
        // start beats a simultaneous rx_valid: rx_ready is 0 here anyway.
        if (start) begin
          state_next = CNT_HI;
          start_load = 1'b1;
        end
      end
      CNT_HI: begin
        if (accept) state_next = CNT_LO;
      end
      CNT_LO: begin
        if (accept) begin
          if (count_bad) begin
            state_next = ERROR;
            load_bad   = 1'b1;
          end else begin
            state_next = WORD_HI;
          end
        end
      end
      WORD_HI: begin
        if (accept) state_next = WORD_LO;
      end
      WORD_LO: begin
        if (accept) begin
          write_word = 1'b1;
          state_next = (word_cnt_inc == n_words) ? CHECK : WORD_HI;
        end
      end
      CHECK: begin
        if (accept) begin
          if (sum_next == 8'h00) begin
            state_next = DONE;
            load_ok    = 1'b1;
          end else begin
            state_next = ERROR;
            load_bad   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum        <= 8'h00;
      count_hi   <= 8'h00;
      word_hi    <= 8'h00;
      n_words    <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Strobe is high only in the cycle after a WORD_LO accept edge.
      imem_we <= write_word;

      if (start_load) begin
        sum       <= 8'h00;
        word_cnt  <= '0;
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_reset <= 1'b1;
      end

      // start_load and accept are never true together: start is only
      // honoured in states where rx_ready is 0.
      if (accept) sum <= sum_next;

      if (accept && (state == CNT_HI)) count_hi <= rx_data;

      if (accept && (state == CNT_LO)) n_words <= (ADDR_W + 1)'(count_full);

      if (accept && (state == WORD_HI)) word_hi <= rx_data;

      if (write_word) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= DATA_W'({word_hi, rx_data});
        word_cnt   <= word_cnt_inc;
      end

      if (load_ok) begin
        done      <= 1'b1;
        cpu_reset <= 1'b0;
      end

      // Words already written stay in memory; only the flag records failure.
      if (load_bad) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toy_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_toy_boot_loader
//
// Directed bench for toy_boot_loader. Stimulus pushes each expected
// instruction-memory write {addr, data} into a queue; an independent monitor
// pops and compares on every imem_we pulse. Status levels are compared after
// each frame against hand-computed values.
// ---------------------------------------------------------------------------
module tb_toy_boot_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  int compared   = 0;
  int mismatched = 0;

  // Expected writes: {addr, data}.
  logic [27:0] sb_q[$];
  logic [11:0] last_wr_addr;

  toy_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {4'h0, imem_addr, imem_wdata}, 32'hDEAD_BEEF);
      end else begin
        logic [27:0] exp_wr;
        exp_wr = sb_q.pop_front();
        check("imem_write", {4'h0, imem_addr, imem_wdata}, {4'h0, exp_wr});
      end
      last_wr_addr = imem_addr;
    end
  end

  task automatic expect_write(input logic [11:0] addr, input logic [15:0] data);
    sb_q.push_back({addr, data});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted. With gaps set, rx_valid is
  // first held low for a random 0..3 cycles. Returns #1 after the accept edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Nominal two-word frame: 00 02 12 34 A0 05 <chk>; chk 0x13 is correct.
  task automatic send_nominal(input logic [7:0] chk, input bit gaps);
    expect_write(12'h000, 16'h1234);
    expect_write(12'h001, 16'hA005);
    send_byte(8'h00, gaps);
    send_byte(8'h02, gaps);
    send_byte(8'h12, gaps);
    send_byte(8'h34, gaps);
    send_byte(8'hA0, gaps);
    send_byte(8'h05, gaps);
    send_byte(chk,   gaps);
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sum;
    logic [15:0] w;

    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rx_ready",  32'(rx_ready),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_imem_we",   32'(imem_we),   32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_data", 32'(imem_wdata), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1. Nominal load; start arrives with a stray valid byte that must be
    //    ignored (rx_ready is 0 in IDLE).
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    pulse_start();
    rx_valid = 1'b0;
    check("start_busy",     32'(busy),     32'd1);
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    send_nominal(8'h13, 1'b0);
    check("nom_done",      32'(done),      32'd1);
    check("nom_error",     32'(error),     32'd0);
    check("nom_cpu_reset", 32'(cpu_reset), 32'd0);
    check("nom_rx_ready",  32'(rx_ready),  32'd0);
    check_drained("nom_drain");

    // 2. Start in DONE: clears done, raises cpu_reset. Bad checksum frame.
    pulse_start();
    check("restart_done",      32'(done),      32'd0);
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    send_nominal(8'h14, 1'b0);
    check("badchk_error",     32'(error),     32'd1);
    check("badchk_done",      32'(done),      32'd0);
    check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
    check_drained("badchk_drain");

    // 3. Bad count N = 0 and N = 0x1001: ERROR on the second byte, no writes.
    pulse_start();
    check("cnt0_error_cleared", 32'(error), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("cnt0_error",    32'(error),    32'd1);
    check("cnt0_rx_ready", 32'(rx_ready), 32'd0);
    pulse_start();
    send_byte(8'h10, 1'b0);
    send_byte(8'h01, 1'b0);
    check("cnt1001_error",    32'(error),    32'd1);
    check("cnt1001_rx_ready", 32'(rx_ready), 32'd0);
    check_drained("badcnt_drain");

    // 4. Nominal frame with random gaps between bytes.
    pulse_start();
    send_nominal(8'h13, 1'b1);
    check("gap_done",      32'(done),      32'd1);
    check("gap_error",     32'(error),     32'd0);
    check("gap_cpu_reset", 32'(cpu_reset), 32'd0);
    check_drained("gap_drain");

    // 5. Reset mid-load while the first write strobe is high.
    pulse_start();
    expect_write(12'h000, 16'h1234);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_imem_we",   32'(imem_we),   32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_busy",      32'(busy),      32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    expect_write(12'h000, 16'hBEEF);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'h52, 1'b0);
    check("postrst_done",      32'(done),      32'd1);
    check("postrst_cpu_reset", 32'(cpu_reset), 32'd0);
    check_drained("postrst_drain");

    // 6. Start pulse during WORD_HI is ignored.
    pulse_start();
    expect_write(12'h000, 16'h1234);
    expect_write(12'h001, 16'hA005);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    pulse_start();
    check("busy_start_done", 32'(done), 32'd0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h13, 1'b0);
    check("busy_start_done_end",  32'(done),  32'd1);
    check("busy_start_error_end", 32'(error), 32'd0);
    check_drained("busy_start_drain");

    // 7. Maximum-size frame, N = 0x1000, word i = i ^ 0x5A3C.
    pulse_start();
    sum = 8'h10;
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 4096; i++) begin
      w = 16'(i) ^ 16'h5A3C;
      expect_write(12'(i), w);
      sum = sum + w[15:8] + w[7:0];
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0],  1'b0);
    end
    send_byte(8'h00 - sum, 1'b0);
    check("max_done",  32'(done),  32'd1);
    check("max_error", 32'(error), 32'd0);
    check_drained("max_drain");
    check("max_last_addr", 32'(last_wr_addr), 32'h0000_0FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/toy_boot_loader.md
# toy_boot_loader

Byte-stream program loader that sits directly upstream of the Toy CPU's instruction memory. It accepts a framed program image over a valid/ready byte interface and writes it word by word into the instruction memory write port. It holds the CPU in reset until a complete image with a correct checksum has been loaded. On completion it releases the CPU so execution starts at pc = 0.

## Interface

Parameters:
- ADDR_W, 12, instruction-memory address width. The maximum image size is 2^ADDR_W words.
- DATA_W, 16, instruction word width. This value is fixed; each word is sent as two bytes.

Ports:
- clk, input, 1, clock. All state changes on the rising edge.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, single-cycle request to begin a load. Accepted only in IDLE, DONE or ERROR.
- rx_data, input, 8, incoming byte.
- rx_valid, input, 1, rx_data is valid.
- rx_ready, output, 1, loader can accept a byte.
- imem_we, output, 1, instruction memory write strobe. One cycle per word.
- imem_addr, output, ADDR_W, write address.
- imem_wdata, output, 16, write data.
- cpu_reset, output, 1, hold for the Toy CPU reset input. Active-high.
- busy, output, 1, a load is in progress.
- done, output, 1, last load succeeded. Level output.
- error, output, 1, last load failed. Level output.

## Operation

- Frame format, in order: COUNT_HI, COUNT_LO, then N words sent high byte first, then CHK.
  - N is the 16-bit big-endian value formed by the two count bytes.
  - CHK is chosen so that the 8-bit sum, mod 256, of every frame byte including CHK is 0x00.
- A byte is accepted on a clock edge where rx_valid && rx_ready. Bytes with rx_valid=0 are ignored and produce no state change.
- State machine states: IDLE, CNT_HI, CNT_LO, WORD_HI, WORD_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start → CNT_HI. On this edge:
  - clear done and error;
  - set cpu_reset = 1;
  - clear the running sum and the word counter.
- CNT_HI + accept → CNT_LO.
- CNT_LO + accept: the full count is now known.
  - If N == 0 or N > 2^ADDR_W → ERROR.
  - Otherwise → WORD_HI.
- WORD_HI + accept → WORD_LO. The byte is latched as the high half of the word.
- WORD_LO + accept:
  - issue a write of {hi, byte} at address = word counter;
  - increment the word counter;
  - if the counter reaches N → CHECK, else → WORD_HI.
- CHECK + accept: add the byte to the running sum.
  - If the sum mod 256 is 0 → DONE: done = 1, cpu_reset = 0.
  - Otherwise → ERROR: error = 1, cpu_reset stays 1.
- Running sum: 8-bit wrap-around. Every accepted byte from COUNT_HI through CHK is added.
- rx_ready = 1 exactly in CNT_HI, CNT_LO, WORD_HI, WORD_LO and CHECK.
- busy = 1 in the same states as rx_ready.
- start while busy is ignored.
- Words already written before an ERROR are not rolled back.
- Word counter width is ADDR_W+1 so that N = 2^ADDR_W can be counted. imem_addr takes the low ADDR_W bits.

## Timing

- Reset values:
  - state = IDLE;
  - cpu_reset = 1;
  - rx_ready, busy, done, error, imem_we = 0;
  - imem_addr = 0, imem_wdata = 0.
- All outputs are registered, except rx_ready and busy, which decode the current state.
- imem_we rises for exactly one cycle, in the cycle after the WORD_LO accept edge. imem_addr and imem_wdata are valid in that same cycle.
- Back-to-back bytes: the loader sustains 1 byte per cycle. The minimum spacing between imem_we pulses is 2 cycles.
- Load latency: done and cpu_reset=0 appear one cycle after the CHK accept edge. A gap-free N-word load takes 2N+3 accepted bytes.
- The ERROR transition on a bad count happens on the COUNT_LO accept edge. rx_ready is 0 from the next cycle.
- Reset mid-load aborts immediately and asynchronously:
  - imem_we = 0 and cpu_reset = 1 at once;
  - state = IDLE;
  - the next load starts again at address 0.
- start asserted in the same cycle as rx_valid while in IDLE: start wins. The byte is not accepted because rx_ready = 0.

## Test plan

- Nominal load: start, then send bytes 00 02 12 34 A0 05 13.
  - Expect imem writes 0x000 = 0x1234 and 0x001 = 0xA005.
  - Then done = 1, error = 0, cpu_reset = 0, rx_ready = 0.
- Bad checksum: same frame with a last byte of 0x14.
  - Both writes still occur.
  - Then error = 1, done = 0, cpu_reset stays 1.
- Bad count: frame 00 00 → ERROR after the second byte, no imem_we, rx_ready = 0. Repeat with 10 01 (N = 0x1001) → same response.
- Backpressure and gaps: nominal frame with rx_valid deasserted randomly between bytes.
  - Identical writes and final state.
  - Each byte is counted exactly once per accept edge.
- Reset mid-load:
  - Assert reset after the first word write; expect IDLE, cpu_reset = 1, imem_we = 0.
  - Start a new frame 00 01 BE EF 52; expect a write 0x000 = 0xBEEF and done = 1.
- Restart and ignore rules:
  - A start pulse during WORD_HI has no effect on the load.
  - A start in DONE clears done, raises cpu_reset and accepts a new frame.
  - A maximum-size frame (N = 0x1000) ends with its last write at address 0xFFF.
